limn2600_write_buffer: RTL and testbench

Posted-write buffer between the Limn2600 CPU bus master and the SRAM. CPU writes complete in one cycle into a DEPTH-entry FIFO that drains to memory in the background. CPU reads are forwarded from the buffer on an address hit; otherwise they wait for the buffer to drain and are then passed through to memory. The block inserts transparently between the CPU and SRAM bus ports of the system top.

---
 rtl/limn2600_write_buffer.sv | 146 ++++++++++++++
 tb/tb_limn2600_write_buffer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limn2600_write_buffer.sv
// Posted-write buffer between the Limn2600 CPU bus and SRAM.
// CPU writes retire into a small FIFO that drains in the background;
// reads forward from the newest matching entry or wait for the drain and go to memory.
module limn2600_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_rdy,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_rdy,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RDWAIT, RDMEM, RESP} state_t;

  state_t            state, state_next;
  logic [31:0]       addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, head_idx;
  logic [CNT_W-1:0]  count, count_next, remaining;
  logic              drain_busy, pop, push, room, hit, drain_next;
  logic [31:0]       hit_data;

  assign drain_busy = mem_cs & mem_we;
  assign pop        = drain_busy & mem_rdy;
  assign room       = (count < CNT_W'(DEPTH)) | pop;
  assign remaining  = count - CNT_W'(pop);
  assign head_idx   = rd_ptr + PTR_W'(pop);
  assign drain_next = (remaining != '0) && (state_next != RDMEM);

  // Address match across valid entries, oldest to newest so the newest wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_q[rd_ptr + PTR_W'(i)] == cpu_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[rd_ptr + PTR_W'(i)];
      end
    end
  end

  // CPU-side next state and push decision
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_cs) begin
          if (cpu_we) begin
            if (room) begin
              push       = 1'b1;
              state_next = RESP;
            end
          end else if (hit) begin
            state_next = RESP;
          end else if ((count == '0) && !drain_busy) begin
            state_next = RDMEM;  // already drained: no need to dwell in RDWAIT
          end else begin
            state_next = RDWAIT;
          end
        end
      end
      RDWAIT: if ((count == '0) && !drain_busy) state_next = RDMEM;
      RDMEM:  if (mem_rdy) state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel
  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Buffer storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= cpu_addr;
      data_q[wr_ptr] <= cpu_data_in;
    end
  end

  // Pointers, count and all registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cpu_rdy      <= 1'b0;
      cpu_data_out <= '0;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      empty        <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      empty   <= (count_next == '0);
      cpu_rdy <= (state_next == RESP);

      if ((state == IDLE) && cpu_cs && !cpu_we && hit)
        cpu_data_out <= hit_data;
      else if ((state == RDMEM) && mem_rdy)
        cpu_data_out <= mem_data_in;

      if (state_next == RDMEM) begin
        mem_cs   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= cpu_addr;
      end else if (drain_next) begin
        mem_cs       <= 1'b1;
        mem_we       <= 1'b1;
        mem_addr     <= addr_q[head_idx];
        mem_data_out <= data_q[head_idx];
      end else begin
        mem_cs <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_limn2600_write_buffer.sv
// Self-checking bench: directed timing steps followed by random traffic
// checked against a sequentially consistent memory model.
module tb_limn2600_write_buffer;

  localparam int M_STALL = 0;
  localparam int M_READY = 1;
  localparam int M_PULSE = 2;
  localparam int M_RAND  = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_we;
  logic [31:0] cpu_addr, cpu_data_in, cpu_data_out;
  logic        cpu_rdy;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_data_out;
  logic [31:0] mem_data_in = '0;
  logic        mem_rdy = 1'b0;
  logic        empty;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_mode = M_STALL;
  int pulse_cyc = -1;
  int first_rd_cyc = -1;
  int rd_cyc = -1;
  int rd_cnt = 0;
  int rdy_cyc = 0;

  wr_t         wlog[$];
  wr_t         expw[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] shadow  [logic [31:0]];

  limn2600_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_rdy(cpu_rdy),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_rdy(mem_rdy), .empty(empty)
  );

  always #5 clk = ~clk;

  // Cycle index; stable from just after each rising edge to the next
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM model: decides mem_rdy mid-cycle and logs the completing transaction
  always @(negedge clk) begin
    mem_rdy = 1'b0;
    if (!rst && mem_cs) begin
      case (mem_mode)
        M_READY: mem_rdy = 1'b1;
        M_PULSE: mem_rdy = (cyc == pulse_cyc);
        M_RAND:  mem_rdy = ($urandom_range(0, 2) != 0);
        default: mem_rdy = 1'b0;
      endcase
      if (!mem_we && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (mem_rdy) begin
        if (mem_we) begin
          wlog.push_back('{addr: mem_addr, data: mem_data_out, cyc: cyc});
          mem_arr[mem_addr] = mem_data_out;
        end else begin
          mem_data_in = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
          rd_cnt++;
          rd_cyc = cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU request; drives at the current time and returns just after the cpu_rdy edge
  task automatic cpu_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd);
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_data_in = d;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_rdy) break;
    end
    rd = cpu_data_out;
    rdy_cyc = cyc;
    chk("req_done", 32'(cpu_rdy), 32'd1);
    cpu_cs = 1'b0;
  endtask

  task automatic wait_empty(output int ecyc);
    int n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (empty) break;
    end
    ecyc = cyc;
    chk("drain_done", 32'(empty), 32'd1);
  endtask

  int          lat, ecyc, rd0, t0;
  logic [31:0] rd, a, d, exp_rd;
  logic        we, rdy_seen, ok;

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t observed, finish required earlier", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd0);
    chk("rst_cpu_data_out", cpu_data_out, 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data_out", mem_data_out, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Single write, drain on cycle 2
    wlog.delete();
    mem_mode = M_STALL;
    cpu_req(1'b1, 32'h100, 32'hDEAD_BEEF, lat, rd);
    chk("wr1_lat", 32'(lat), 32'd1);
    chk("wr1_empty_fell", 32'(empty), 32'd0);
    @(posedge clk); #1;
    chk("wr1_mem_cs", 32'(mem_cs), 32'd1);
    chk("wr1_mem_we", 32'(mem_we), 32'd1);
    chk("wr1_mem_addr", mem_addr, 32'h100);
    chk("wr1_mem_data", mem_data_out, 32'hDEAD_BEEF);
    mem_mode = M_READY;
    @(posedge clk); #1;
    chk("wr1_empty_rose", 32'(empty), 32'd1);
    chk("wr1_mem_cs_off", 32'(mem_cs), 32'd0);
    chk("wr1_log_n", 32'(wlog.size()), 32'd1);
    chk("wr1_log_data", (wlog.size() == 1) ? wlog[0].data : 32'h0, 32'hDEAD_BEEF);

    // Fill the buffer, fifth write waits for the first pop
    wlog.delete();
    mem_mode = M_STALL;
    for (int i = 0; i < 4; i++) begin
      cpu_req(1'b1, 32'(i * 4), 32'h1000 + 32'(i), lat, rd);
      chk("fill_lat", 32'(lat), (i == 0) ? 32'd1 : 32'd2);
    end
    pulse_cyc = cyc + 4;
    mem_mode  = M_PULSE;
    cpu_req(1'b1, 32'h10, 32'h1004, lat, rd);
    chk("full_wr_lat", 32'(lat), 32'd5);
    chk("full_wr_rdy_cyc", 32'(rdy_cyc), 32'(pulse_cyc + 1));
    chk("full_wr_one_pop", 32'(wlog.size()), 32'd1);
    mem_mode = M_READY;
    wait_empty(ecyc);
    chk("fill_log_n", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("fill_order_addr", wlog[i].addr, 32'(i * 4));
        chk("fill_order_data", wlog[i].data, 32'h1000 + 32'(i));
      end
      for (int i = 1; i < 5; i++)
        chk("fill_back_to_back", 32'(wlog[i].cyc), 32'(wlog[i-1].cyc + 1));
      chk("fill_empty_cyc", 32'(ecyc), 32'(wlog[4].cyc + 1));
    end

    // Read hit forwards the newest of two matching entries
    wlog.delete();
    mem_mode = M_STALL;
    rd0 = rd_cnt;
    cpu_req(1'b1, 32'h200, 32'h11, lat, rd);
    cpu_req(1'b1, 32'h200, 32'h22, lat, rd);
    @(posedge clk); #1;
    cpu_req(1'b0, 32'h200, 32'h0, lat, rd);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_data", rd, 32'h22);
    chk("hit_no_mem_read", 32'(mem_we), 32'd1);
    mem_mode = M_READY;
    wait_empty(ecyc);
    chk("hit_rd_cnt", 32'(rd_cnt), 32'(rd0));
    chk("hit_log_n", 32'(wlog.size()), 32'd2);
    chk("hit_log_last", (wlog.size() == 2) ? wlog[1].data : 32'h0, 32'h22);

    // Read miss behind two buffered writes
    mem_arr[32'h300] = 32'h0000_CAFE;
    wlog.delete();
    mem_mode = M_STALL;
    cpu_req(1'b1, 32'h304, 32'hA1, lat, rd);
    cpu_req(1'b1, 32'h308, 32'hA2, lat, rd);
    mem_mode = M_READY;
    first_rd_cyc = -1;
    cpu_req(1'b0, 32'h300, 32'h0, lat, rd);
    chk("miss_data", rd, 32'h0000_CAFE);
    ok = (wlog.size() == 2) && (first_rd_cyc > wlog[1].cyc);
    chk("miss_after_drain", 32'(ok), 32'd1);
    chk("miss_rdy_cyc", 32'(rdy_cyc), 32'(rd_cyc + 1));

    // Read miss on an empty buffer, then data holds across a write
    @(posedge clk); #1;
    first_rd_cyc = -1;
    t0 = cyc;
    cpu_req(1'b0, 32'h300, 32'h0, lat, rd);
    chk("miss_empty_cs_cyc", 32'(first_rd_cyc), 32'(t0 + 1));
    chk("miss_empty_lat", 32'(lat), 32'd2);
    chk("miss_empty_data", rd, 32'h0000_CAFE);
    cpu_req(1'b1, 32'h0, 32'h77, lat, rd);
    chk("rdata_hold", cpu_data_out, 32'h0000_CAFE);
    wait_empty(ecyc);

    // Reset with three writes buffered and a drain pending
    wlog.delete();
    mem_mode = M_STALL;
    for (int i = 0; i < 3; i++) cpu_req(1'b1, 32'h400 + 32'(i * 4), 32'hB0 + 32'(i), lat, rd);
    @(posedge clk); #1;
    chk("rst_mid_pending", 32'(mem_cs), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_mid_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    mem_mode = M_READY;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_discard", 32'(wlog.size()), 32'd0);
    chk("rst_mid_empty2", 32'(empty), 32'd1);

    // Reset during a pending memory read gives no cpu_rdy
    mem_mode = M_STALL;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_pending", {30'b0, mem_cs, mem_we}, 32'd2);
    @(negedge clk) begin rst = 1'b1; cpu_cs = 1'b0; end
    @(negedge clk) rst = 1'b0;
    mem_mode = M_READY;
    rdy_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cpu_rdy) rdy_seen = 1'b1;
    end
    chk("rst_rd_no_rdy", 32'(rdy_seen), 32'd0);
    chk("rst_rd_mem_cs", 32'(mem_cs), 32'd0);

    // Random traffic against a sequentially consistent memory model
    mem_arr.delete();
    shadow.delete();
    wlog.delete();
    expw.delete();
    mem_mode = M_RAND;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      if (we) begin
        d = $urandom;
        cpu_req(1'b1, a, d, lat, rd);
        shadow[a] = d;
        expw.push_back('{addr: a, data: d, cyc: 0});
      end else begin
        exp_rd = shadow.exists(a) ? shadow[a] : dflt(a);
        cpu_req(1'b0, a, 32'h0, lat, rd);
        chk("rand_read", rd, exp_rd);
      end
    end
    mem_mode = M_READY;
    wait_empty(ecyc);
    chk("rand_wr_count", 32'(wlog.size()), 32'(expw.size()));
    for (int i = 0; i < expw.size() && i < wlog.size(); i++) begin
      chk("rand_wr_addr", wlog[i].addr, expw[i].addr);
      chk("rand_wr_data", wlog[i].data, expw[i].data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
